// File: rtl/sti_dac_pkg.sv
// Shared types for the STI DAC: serializer FSM states and frame length codes.
package sti_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LEN_HALF  = 2'd0;
    localparam logic [1:0] LEN_FULL  = 2'd1;
    localparam logic [1:0] LEN_1HALF = 2'd2;
    localparam logic [1:0] LEN_TWO   = 2'd3;

endpackage

// File: rtl/sti_dac_multibank_oem_bank_writer.sv
// Packs the serial stream into words and writes them across odd/even bank pairs,
// zero-filling the remaining memory while pad_en is held.
module oem_bank_writer #(
    parameter int WORD_W    = 8,
    parameter int NBANK     = 4,
    parameter int ADDR_W    = 5,
    parameter int ROW_WORDS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_vld,
    input  logic              pad_en,
    input  logic              cfg_checker,
    output logic [WORD_W-1:0] oem_dataout,
    output logic [ADDR_W-1:0] oem_addr,
    output logic [NBANK-1:0]  odd_wr,
    output logic [NBANK-1:0]  even_wr,
    output logic              full
);

    localparam int NB_W = $clog2(NBANK);
    localparam int N_W  = NB_W + ADDR_W + 1;
    localparam int BC_W = $clog2(WORD_W);
    localparam int RW_B = $clog2(ROW_WORDS);

    logic [WORD_W-1:0] shreg;
    logic [BC_W-1:0]   bcnt;
    logic [N_W-1:0]    n;
    logic              word_done, wr_en, is_odd;
    logic [WORD_W-1:0] wr_data;
    logic [NB_W-1:0]   bank;

    assign word_done = bit_vld && (bcnt == BC_W'(WORD_W - 1));
    assign wr_en     = !full && (word_done || pad_en);
    assign wr_data   = pad_en ? '0 : {shreg[WORD_W-2:0], bit_in};
    // Checkerboard flips the odd/even choice on every other image row
    assign is_odd    = (n[0] == 1'b0) ^ (cfg_checker & n[RW_B]);
    assign bank      = n[N_W-1:ADDR_W+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bcnt        <= '0;
            n           <= '0;
            full        <= 1'b0;
            oem_dataout <= '0;
            oem_addr    <= '0;
            odd_wr      <= '0;
            even_wr     <= '0;
        end else begin
            odd_wr  <= '0;
            even_wr <= '0;
            if (bit_vld) begin
                shreg <= {shreg[WORD_W-2:0], bit_in};
                bcnt  <= word_done ? '0 : bcnt + 1'b1;
            end
            if (wr_en) begin
                oem_dataout <= wr_data;
                oem_addr    <= n[ADDR_W:1];
                if (is_odd) odd_wr  <= NBANK'(1) << bank;
                else        even_wr <= NBANK'(1) << bank;
                n <= n + 1'b1;
                // n wraps at the top, so fullness is kept as its own flag
                if (n == '1) full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sti_dac_multibank.sv
// Frame builder and serializer; the serial stream feeds the bank writer which fills memory.
module sti_dac_multibank
    import sti_dac_pkg::*;
#(
    parameter int PI_W      = 16,
    parameter int WORD_W    = 8,
    parameter int NBANK     = 4,
    parameter int ADDR_W    = 5,
    parameter int ROW_WORDS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [PI_W-1:0]   pi_data,
    input  logic [1:0]        pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    input  logic              cfg_checker,
    output logic              busy,
    output logic              so_data,
    output logic              so_valid,
    output logic [WORD_W-1:0] oem_dataout,
    output logic [ADDR_W-1:0] oem_addr,
    output logic [NBANK-1:0]  odd_wr,
    output logic [NBANK-1:0]  even_wr,
    output logic              oem_finish
);

    localparam int FW = 2 * PI_W;
    localparam int LW = $clog2(FW + 1);

    state_t          state;
    logic [FW-1:0]   sreg, frame, fj;
    logic [LW-1:0]   cnt, flen;
    logic            msb_q, end_q, mem_full;

    // Frame is built right-justified; MSB-first frames are then moved to the top
    // so both orders shift out of a fixed end of sreg.
    always_comb begin
        frame = '0;
        flen  = LW'(PI_W);
        case (pi_length)
            LEN_HALF: begin
                flen = LW'(PI_W / 2);
                frame[PI_W/2-1:0] = pi_low ? pi_data[PI_W-1:PI_W/2] : pi_data[PI_W/2-1:0];
            end
            LEN_FULL: frame[PI_W-1:0] = pi_data;
            LEN_1HALF: begin
                flen  = LW'(3 * PI_W / 2);
                frame = pi_fill ? FW'(pi_data) << (PI_W / 2) : FW'(pi_data);
            end
            default: begin
                flen  = LW'(FW);
                frame = pi_fill ? FW'(pi_data) << PI_W : FW'(pi_data);
            end
        endcase
        fj = pi_msb ? frame << (LW'(FW) - flen) : frame;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            so_data    <= 1'b0;
            so_valid   <= 1'b0;
            sreg       <= '0;
            cnt        <= '0;
            msb_q      <= 1'b0;
            end_q      <= 1'b0;
            oem_finish <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        so_valid <= 1'b1;
                        so_data  <= pi_msb ? fj[FW-1] : fj[0];
                        sreg     <= pi_msb ? fj << 1 : fj >> 1;
                        cnt      <= flen - LW'(1);
                        msb_q    <= pi_msb;
                        end_q    <= pi_end;
                    end else if (pi_end) begin
                        busy <= 1'b1;
                        if (mem_full) begin
                            state      <= DONE;
                            oem_finish <= 1'b1;
                        end else begin
                            state <= PAD;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        so_valid <= 1'b0;
                        so_data  <= 1'b0;
                        if (end_q) begin
                            state <= PAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        so_data <= msb_q ? sreg[FW-1] : sreg[0];
                        sreg    <= msb_q ? sreg << 1 : sreg >> 1;
                        cnt     <= cnt - LW'(1);
                    end
                end
                PAD: begin
                    if (mem_full) begin
                        state      <= DONE;
                        oem_finish <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    oem_bank_writer #(
        .WORD_W   (WORD_W),
        .NBANK    (NBANK),
        .ADDR_W   (ADDR_W),
        .ROW_WORDS(ROW_WORDS)
    ) u_writer (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (so_data),
        .bit_vld    (so_valid),
        .pad_en     (state == PAD),
        .cfg_checker(cfg_checker),
        .oem_dataout(oem_dataout),
        .oem_addr   (oem_addr),
        .odd_wr     (odd_wr),
        .even_wr    (even_wr),
        .full       (mem_full)
    );

endmodule

// File: tb/tb_sti_dac_multibank.sv
// Scoreboard bench: scenarios queue expected serial bits and memory writes, a monitor checks them.
module tb_sti_dac_multibank;

    localparam int PI_W = 16, WORD_W = 8, NBANK = 4, ADDR_W = 5, ROW_WORDS = 8;
    localparam int WR_W = 2 * NBANK + ADDR_W + WORD_W;

    logic clk = 1'b0, reset = 1'b1, load = 1'b0, pi_fill = 1'b0, pi_msb = 1'b1;
    logic pi_low = 1'b0, pi_end = 1'b0, cfg_checker = 1'b0;
    logic [PI_W-1:0] pi_data = '0;
    logic [1:0] pi_length = 2'd0;
    logic busy, so_data, so_valid, oem_finish;
    logic [WORD_W-1:0] oem_dataout;
    logic [ADDR_W-1:0] oem_addr;
    logic [NBANK-1:0] odd_wr, even_wr;

    int nvec = 0, nmis = 0, sv_cnt = 0;
    bit sb_off = 1'b0;
    bit bit_q[$];
    logic [WR_W-1:0] wr_q[$];

    sti_dac_multibank dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .cfg_checker(cfg_checker), .busy(busy), .so_data(so_data), .so_valid(so_valid),
        .oem_dataout(oem_dataout), .oem_addr(oem_addr), .odd_wr(odd_wr), .even_wr(even_wr),
        .oem_finish(oem_finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WR_W-1:0] mk_wr(input int bank, input bit odd, input int addr,
                                              input logic [WORD_W-1:0] d);
        logic [NBANK-1:0] oh, o, e;
        oh = NBANK'(1) << bank;
        o  = odd ? oh : '0;
        e  = odd ? '0 : oh;
        return {o, e, ADDR_W'(addr), d};
    endfunction

    // Monitor: consumes expectations whenever the DUT presents a bit or a write
    always @(negedge clk) begin
        if (!reset) begin
            if (so_valid) begin
                sv_cnt++;
                if (!sb_off) begin
                    if (bit_q.size() == 0) chk("so_unexpected", 1, 0);
                    else chk("so_data", so_data, bit_q.pop_front());
                end
            end else if (so_data) begin
                chk("so_data_idle", so_data, 0);
            end
            if (|odd_wr || |even_wr) begin
                if (wr_q.size() == 0) chk("wr_unexpected", {odd_wr, even_wr, oem_addr, oem_dataout}, 0);
                else chk("wr", {odd_wr, even_wr, oem_addr, oem_dataout}, wr_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; pi_end = 1'b0;
        bit_q.delete(); wr_q.delete();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic push_bits(input logic [31:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) bit_q.push_back(b[i]);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] len, input bit fill,
                        input bit msb, input bit low, input bit endf);
        int t = 0;
        while (busy && t < 200) begin tick(); t++; end
        chk("idle_before_load", busy, 0);
        pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low;
        load = 1'b1; pi_end = endf;
        tick();
        load = 1'b0; pi_end = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((bit_q.size() + wr_q.size()) != 0 && t < 2000) begin tick(); t++; end
        chk({name, "_drain"}, bit_q.size() + wr_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] odd_pat;
        logic [7:0]  d8;
        #1;
        chk("rst_outs", {busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);

        // code 1, MSB first
        do_reset();
        push_bits(32'hA5C3, 16);
        wr_q.push_back(mk_wr(0, 1, 0, 8'hA5));
        wr_q.push_back(mk_wr(0, 0, 0, 8'hC3));
        sv_cnt = 0;
        send(16'hA5C3, 2'd1, 0, 1, 0, 0);
        drain("s1");
        chk("s1_valid_cycles", sv_cnt, 16);
        chk("s1_idle", busy, 0);

        // code 0, upper half, LSB first
        do_reset();
        push_bits(32'b10000001, 8);
        wr_q.push_back(mk_wr(0, 1, 0, 8'h81));
        sv_cnt = 0;
        send(16'h8100, 2'd0, 0, 0, 1, 0);
        drain("s2");
        chk("s2_valid_cycles", sv_cnt, 8);

        // code 2 right-justified; load and pi_end during busy are ignored
        do_reset();
        push_bits(32'h001234, 24);
        wr_q.push_back(mk_wr(0, 1, 0, 8'h00));
        wr_q.push_back(mk_wr(0, 0, 0, 8'h12));
        wr_q.push_back(mk_wr(0, 1, 1, 8'h34));
        sv_cnt = 0;
        send(16'h1234, 2'd2, 0, 1, 0, 0);
        repeat (3) tick();
        pi_data = 16'hFFFF; pi_length = 2'd3; load = 1'b1; pi_end = 1'b1;
        tick();
        load = 1'b0; pi_end = 1'b0;
        drain("s3");
        chk("s3_valid_cycles", sv_cnt, 24);
        chk("s3_idle", busy, 0);
        repeat (5) tick();

        // checkerboard mapping over two rows of 8 words
        do_reset();
        cfg_checker = 1'b1;
        odd_pat = 16'hAA55;
        for (int k = 0; k < 16; k++) begin
            d8 = 8'hC0 + 8'(k);
            push_bits({24'h0, d8}, 8);
            wr_q.push_back(mk_wr(0, odd_pat[k], k >> 1, d8));
            send({d8, 8'h00}, 2'd0, 0, 1, 1, 0);
        end
        drain("s4");
        repeat (3) tick();
        cfg_checker = 1'b0;

        // two frames, the second with pi_end, then zero padding to the end of memory
        do_reset();
        push_bits(32'h11, 8);
        wr_q.push_back(mk_wr(0, 1, 0, 8'h11));
        push_bits(32'h22, 8);
        wr_q.push_back(mk_wr(0, 0, 0, 8'h22));
        for (int n = 2; n < 256; n++)
            wr_q.push_back(mk_wr(n >> 6, (n % 2) == 0, (n % 64) >> 1, 8'h00));
        send(16'h1100, 2'd0, 0, 1, 1, 0);
        send(16'h2200, 2'd0, 0, 1, 1, 1);
        drain("s5");
        chk("s5_finish", oem_finish, 1);
        chk("s5_busy", busy, 1);
        load = 1'b1; pi_end = 1'b1;
        tick();
        load = 1'b0; pi_end = 1'b0;
        repeat (10) tick();
        chk("s5_finish_held", {oem_finish, busy}, 2'b11);

        // reset at bit 5 of a frame, then a clean frame restarts at address 0
        do_reset();
        sb_off = 1'b1;
        send(16'hF0F0, 2'd1, 0, 1, 0, 0);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("s6_rst_outs", {busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);
        tick(); tick();
        reset = 1'b0;
        sb_off = 1'b0;
        repeat (12) tick();
        chk("s6_quiet", {odd_wr, even_wr, so_valid, busy}, 0);
        push_bits(32'h5A, 8);
        wr_q.push_back(mk_wr(0, 1, 0, 8'h5A));
        send(16'h5A00, 2'd0, 0, 1, 1, 0);
        drain("s6");
        repeat (3) tick();

        chk("end_queues", bit_q.size() + wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
